// File: rtl/sim_run_controller.sv
// Run controller for CPU simulation: reset pulse, cycle limit, PC-stall
// halt detection and a trace FIFO of captured io writes.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   pc_fetch        CPU fetch PC, watched for a stall
//   io_we, io_out   per-channel io write strobes and data
//   cpu_rst_n       active-low CPU reset (low in hold and after done)
//   running, done   run state flags, done is sticky until rst
//   halt_reason     00 none, 01 cycle limit, 10 pc stall
//   cycle_count     completed RUN cycles
//   trace_rd        pop request for the trace FIFO head
//   trace_valid     FIFO non-empty, head fields below are meaningful
//   trace_chan/data/cycle  registered FIFO head
//   trace_overflow  sticky, an io write was dropped
//
// Optional macro SIM_RUN_TRACE_DISPLAY_EN adds simulation $display
// tracing; port behaviour is identical with or without it.
module sim_run_controller #(
  parameter int XLEN        = 32,
  parameter int N_IO        = 4,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 15,
  parameter int HALT_STABLE = 4,
  parameter int TRACE_DEPTH = 16,
  localparam int CW = (N_IO > 1) ? $clog2(N_IO) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      pc_fetch,
  input  logic [N_IO-1:0]      io_we,
  input  logic [N_IO*XLEN-1:0] io_out,
  output logic                 cpu_rst_n,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           halt_reason,
  output logic [31:0]          cycle_count,
  input  logic                 trace_rd,
  output logic                 trace_valid,
  output logic [CW-1:0]        trace_chan,
  output logic [XLEN-1:0]      trace_data,
  output logic [31:0]          trace_cycle,
  output logic                 trace_overflow
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = $clog2(HALT_STABLE);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int EW = CW + XLEN + 32;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [XLEN-1:0] prev_q, prev_d;
  logic            first_q, first_d;
  logic [31:0]     cyc_d;
  logic [1:0]      reason_d;
  logic            pc_same;
  logic            limit_hit;
  logic            stall_hit;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stall_d   = stall_q;
    prev_d    = prev_q;
    first_d   = first_q;
    cyc_d     = cycle_count;
    reason_d  = halt_reason;
    pc_same   = 1'b0;
    limit_hit = 1'b0;
    stall_hit = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        if (hold_q == HW'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
          first_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        cyc_d   = cycle_count + 32'd1;
        prev_d  = pc_fetch;
        first_d = 1'b0;
        // No previous PC exists in the first RUN cycle
        pc_same = !first_q && (pc_fetch == prev_q);
        stall_d = pc_same ? stall_q + 1'b1 : '0;
        stall_hit = pc_same &&
          (stall_d == SW'(HALT_STABLE - 1));
        limit_hit = (MAX_CYCLES != 0) &&
          (cyc_d == 32'(MAX_CYCLES));
        // Limit wins when both fire together
        if (limit_hit) begin
          state_d  = S_DONE;
          reason_d = 2'b01;
        end else if (stall_hit) begin
          state_d  = S_DONE;
          reason_d = 2'b10;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      stall_q     <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      cycle_count <= '0;
      halt_reason <= 2'b00;
      cpu_rst_n   <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stall_q     <= stall_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      cycle_count <= cyc_d;
      halt_reason <= reason_d;
      cpu_rst_n   <= (state_d == S_RUN);
      running     <= (state_d == S_RUN);
      done        <= (state_d == S_DONE);
    end
  end

  // Capture: lowest-index strobe wins
  logic            cap_any;
  logic            cap_multi;
  logic [CW-1:0]   cap_chan;
  logic [XLEN-1:0] cap_data;

  always_comb begin
    cap_chan = '0;
    cap_data = '0;
    for (int i = N_IO - 1; i >= 0; i--) begin
      if (io_we[i]) begin
        cap_chan = CW'(i);
        cap_data = io_out[i*XLEN +: XLEN];
      end
    end
  end

  assign cap_any   = (state_q == S_RUN) && (|io_we);
  assign cap_multi = cap_any &&
    (|(io_we & (io_we - 1'b1)));

  // Trace FIFO with registered head
  logic [EW-1:0] mem [TRACE_DEPTH];
  logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
  logic [EW-1:0] entry;
  logic [EW-1:0] head_d;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          valid_d;

  assign full = (wr_q[AW] != rd_q[AW]) &&
    (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = trace_rd && trace_valid;
  assign push_ok = cap_any && (!full || pop);
  assign drop    = cap_multi || (cap_any && !push_ok);
  assign entry   = {cap_chan, cap_data, cycle_count};
  assign rd_d    = rd_q + (AW + 1)'(pop);
  assign wr_d    = wr_q + (AW + 1)'(push_ok);
  assign valid_d = (rd_d != wr_d);

  // A freshly pushed word that becomes the head bypasses the array
  always_comb begin
    if (push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
      head_d = entry;
    end else begin
      head_d = mem[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_q[AW-1:0]] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q           <= '0;
      rd_q           <= '0;
      trace_valid    <= 1'b0;
      trace_chan     <= '0;
      trace_data     <= '0;
      trace_cycle    <= '0;
      trace_overflow <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      trace_valid <= valid_d;
      {trace_chan, trace_data, trace_cycle} <= head_d;
      if (drop) begin
        trace_overflow <= 1'b1;
      end
    end
  end

`ifdef SIM_RUN_TRACE_DISPLAY_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_RUN) begin
        $display("[run] cycle %0d pc %h",
          cycle_count, pc_fetch);
      end
      if (cap_any) begin
        $display("io%0d <= %h", cap_chan, cap_data);
      end
      if (drop) begin
        $display("[run] io write dropped, cycle %0d",
          cycle_count);
      end
      if (state_q != S_DONE && state_d == S_DONE) begin
        $display("[run] done reason %0d cycles %0d ovf %0b",
          reason_d, cyc_d, trace_overflow | drop);
      end
    end
  end
`endif

endmodule
